// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM state type and byte/word helpers.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ke_state_e;

    // GF(2^8) multiply-by-two, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // {a,b,c,d} -> {b,c,d,a}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in and round-key-out valid/ready streams of the AES key schedule block.
interface aes_key_expand_if;
    logic [127:0] KEY_IN;
    logic         KEY_VALID;
    logic         KEY_READY;
    logic [127:0] RK_OUT;
    logic [3:0]   RK_ROUND;
    logic         RK_LAST;
    logic         RK_VALID;
    logic         RK_READY;

    modport master (
        output KEY_IN, KEY_VALID, RK_READY,
        input  KEY_READY, RK_OUT, RK_ROUND, RK_LAST, RK_VALID
    );

    modport slave (
        input  KEY_IN, KEY_VALID, RK_READY,
        output KEY_READY, RK_OUT, RK_ROUND, RK_LAST, RK_VALID
    );
endinterface

// File: rtl/AES_Sbox.sv
// AES forward S-box, one byte.
// Latency: combinational.
// Backpressure: none (pure lookup).
module AES_Sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Entry 0 sits in the top byte, so the lookup index is counted from the MSB end.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];
endmodule

// File: rtl/aes_sub_word.sv
// SubWord: S-box applied to each byte of a 32-bit word.
// Latency: combinational.
// Backpressure: none (pure function).
module aes_sub_word (
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        AES_Sbox u_sbox (
            .in_byte  (in_word[8*i +: 8]),
            .out_byte (out_word[8*i +: 8])
        );
    end
endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one key in, round keys 0..10 streamed out one per accepted beat.
// Latency: round 0 valid the edge after the key handshake, then one round per RK handshake.
// Backpressure: RK_OUT/RK_ROUND hold while RK_READY is low; KEY_READY stays low until round 10 is taken.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input logic             CLK,
    input logic             RST_N,
    aes_key_expand_if.slave bus
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_expand: only NR = 10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ke_state_e    state_q, state_d;
    logic [127:0] rk_q;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;

    logic         emit;
    logic         key_hs;
    logic         rk_hs;
    logic         at_last;
    logic [31:0]  sub_w;
    logic [31:0]  temp;
    logic [31:0]  acc;
    logic [127:0] next_rk;

    assign emit    = (state_q == EMIT);
    assign key_hs  = bus.KEY_VALID && !emit;
    assign rk_hs   = emit && bus.RK_READY;
    assign at_last = (round_q == LAST_ROUND);

    aes_sub_word u_sub_word (
        .in_word  (rot_word(rk_q[31:0])),
        .out_word (sub_w)
    );

    assign temp = sub_w ^ {rcon_q, 24'h0};

    // Running XOR: each new word is the old word XOR the new word to its left.
    always_comb begin
        acc     = temp;
        next_rk = '0;
        for (int i = 0; i < AES_NK; i++) begin
            acc = acc ^ rk_q[127-32*i -: 32];
            next_rk[127-32*i -: 32] = acc;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_hs) state_d = EMIT;
            EMIT:    if (rk_hs && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rk_q    <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else if (key_hs) begin
            rk_q    <= bus.KEY_IN;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else if (rk_hs && !at_last) begin
            rk_q    <= next_rk;
            round_q <= round_q + 4'd1;
            rcon_q  <= xtime(rcon_q);
        end
    end

    assign bus.KEY_READY = !emit;
    assign bus.RK_VALID  = emit;
    assign bus.RK_LAST   = emit && at_last;
    assign bus.RK_OUT    = rk_q;
    assign bus.RK_ROUND  = round_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 style key-expansion model with derived S-box, per-cycle compare.
module tb_aes_key_expand;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic CLK = 1'b0;
    logic RST_N;

    aes_key_expand_if kif ();

    aes_key_expand #(.NR(10)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (kif)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_tbl [256];

    function automatic logic [7:0] gf_x2(input logic [7:0] a);
        return (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = gf_x2(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [7:0]    rc = 8'h01;
        logic [31:0]   t;
        logic [1407:0] s = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_x2(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            s[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    function automatic logic [127:0] rk_of(input logic [1407:0] s, input int r);
        return s[1407-128*r -: 128];
    endfunction

    // Transaction-level model: busy flag, current round, schedule of the accepted key.
    logic          m_busy  = 1'b0;
    logic [3:0]    m_round = 4'd0;
    logic [127:0]  m_rk    = '0;
    logic [1407:0] m_sched = '0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy  <= 1'b0;
            m_round <= 4'd0;
            m_rk    <= '0;
        end else if (!m_busy) begin
            if (kif.KEY_VALID) begin
                m_busy  <= 1'b1;
                m_sched <= expand(kif.KEY_IN);
                m_round <= 4'd0;
                m_rk    <= kif.KEY_IN;
            end
        end else if (kif.RK_READY) begin
            if (m_round == 4'd10) begin
                m_busy <= 1'b0;
            end else begin
                m_round <= m_round + 4'd1;
                m_rk    <= rk_of(m_sched, int'(m_round) + 1);
            end
        end
    end

    always @(negedge CLK) begin
        check("key_ready", 128'(kif.KEY_READY), 128'(!m_busy));
        check("rk_valid",  128'(kif.RK_VALID),  128'(m_busy));
        check("rk_last",   128'(kif.RK_LAST),   128'(m_busy && m_round == 4'd10));
        check("rk_round",  128'(kif.RK_ROUND),  128'(m_round));
        check("rk_out",    kif.RK_OUT,          m_rk);
    end

    // ---------------- stimulus ----------------
    task automatic run_key(input logic [127:0] key, input bit rand_ready,
                           input logic [127:0] exp_r1, input logic [127:0] exp_r10);
        logic [1407:0] s = expand(key);
        int            nvalid = 0;
        int            nhs = 0;
        bit            hs;
        logic [127:0]  prev_out;
        logic [3:0]    prev_rnd;
        kif.KEY_IN    = key;
        kif.KEY_VALID = 1'b1;
        @(negedge CLK);
        kif.KEY_VALID = 1'b0;
        for (int c = 0; c < 400 && kif.RK_VALID; c++) begin
            nvalid++;
            if (rand_ready) kif.RK_READY = 1'($urandom_range(0, 1));
            else            kif.RK_READY = 1'b1;
            hs       = kif.RK_READY;
            prev_out = kif.RK_OUT;
            prev_rnd = kif.RK_ROUND;
            if (hs) begin
                check("hs_round", 128'(kif.RK_ROUND), 128'(nhs));
                check("hs_value", kif.RK_OUT, rk_of(s, nhs));
                if (nhs == 0)  check("round0_is_key", kif.RK_OUT, key);
                if (nhs == 1)  check("round1_literal", kif.RK_OUT, exp_r1);
                if (nhs == 10) begin
                    check("round10_literal", kif.RK_OUT, exp_r10);
                    check("round10_last", 128'(kif.RK_LAST), 128'(1));
                end
                nhs++;
            end
            @(negedge CLK);
            if (!hs && kif.RK_VALID) begin
                check("stall_out",   kif.RK_OUT,   prev_out);
                check("stall_round", 128'(kif.RK_ROUND), 128'(prev_rnd));
            end
        end
        check("handshake_count", 128'(nhs), 128'(11));
        check("idle_after", 128'(kif.KEY_READY), 128'(1));
        if (!rand_ready) check("valid_cycles", 128'(nvalid), 128'(11));
        kif.RK_READY = 1'b1;
    endtask

    task automatic wait_round(input logic [3:0] r, input string nm);
        int c = 0;
        while (!(kif.RK_VALID && kif.RK_ROUND == r) && c < 50) begin
            @(negedge CLK);
            c++;
        end
        check(nm, 128'(kif.RK_ROUND), 128'(r));
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, "_rk_out"},    kif.RK_OUT,              '0);
        check({nm, "_rk_round"},  128'(kif.RK_ROUND),      128'(0));
        check({nm, "_rk_last"},   128'(kif.RK_LAST),       128'(0));
        check({nm, "_rk_valid"},  128'(kif.RK_VALID),      128'(0));
        check({nm, "_key_ready"}, 128'(kif.KEY_READY),     128'(1));
    endtask

    initial begin
        logic [1407:0] sf;
        logic [1407:0] sz;
        RST_N         = 1'b0;
        kif.KEY_IN    = '0;
        kif.KEY_VALID = 1'b0;
        kif.RK_READY  = 1'b0;

        build_sbox();
        sf = expand(FIPS_KEY);
        sz = expand('0);
        check("model_fips_r1",  rk_of(sf, 1),  FIPS_R1);
        check("model_fips_r10", rk_of(sf, 10), FIPS_R10);
        check("model_zero_r1",  rk_of(sz, 1),  ZERO_R1);
        check("model_zero_r10", rk_of(sz, 10), ZERO_R10);

        #12;
        check_reset_values("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        run_key(FIPS_KEY, 1'b0, FIPS_R1, FIPS_R10);
        run_key('0, 1'b0, ZERO_R1, ZERO_R10);
        run_key(FIPS_KEY, 1'b1, FIPS_R1, FIPS_R10);

        // Offer a second key while busy; it must wait until round 10 has been taken.
        kif.RK_READY  = 1'b1;
        kif.KEY_IN    = FIPS_KEY;
        kif.KEY_VALID = 1'b1;
        @(negedge CLK);
        kif.KEY_VALID = 1'b0;
        wait_round(4'd3, "busy_reach_r3");
        kif.KEY_IN    = '0;
        kif.KEY_VALID = 1'b1;
        wait_round(4'd10, "busy_reach_r10");
        check("busy_r10_value", kif.RK_OUT, FIPS_R10);
        @(negedge CLK);
        check("busy_gap_valid", 128'(kif.RK_VALID), 128'(0));
        check("busy_gap_ready", 128'(kif.KEY_READY), 128'(1));
        @(negedge CLK);
        kif.KEY_VALID = 1'b0;
        check("busy_new_valid", 128'(kif.RK_VALID), 128'(1));
        check("busy_new_r0",    kif.RK_OUT, '0);
        @(negedge CLK);
        check("busy_new_r1",    kif.RK_OUT, ZERO_R1);
        wait_round(4'd10, "busy_zero_r10");
        check("busy_zero_r10_value", kif.RK_OUT, ZERO_R10);
        @(negedge CLK);

        // Reset mid-schedule, then a fresh key must restart rcon from 01.
        kif.KEY_IN    = FIPS_KEY;
        kif.KEY_VALID = 1'b1;
        @(negedge CLK);
        kif.KEY_VALID = 1'b0;
        wait_round(4'd5, "rst_reach_r5");
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge CLK);
        RST_N = 1'b1;
        kif.KEY_IN    = FIPS_KEY;
        kif.KEY_VALID = 1'b1;
        @(negedge CLK);
        kif.KEY_VALID = 1'b0;
        check("after_rst_r0", kif.RK_OUT, FIPS_KEY);
        @(negedge CLK);
        check("after_rst_r1", kif.RK_OUT, FIPS_R1);
        check("after_rst_round", 128'(kif.RK_ROUND), 128'(1));
        wait_round(4'd10, "after_rst_r10");
        check("after_rst_r10_value", kif.RK_OUT, FIPS_R10);
        repeat (3) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES-128 key schedule generator. It accepts one 128-bit cipher key and emits the 11 round keys (round 0 through round 10) one at a time over a valid/ready stream. The stream feeds the AddRoundKey stage that follows sub_bytes/shift_rows/mix_columns in the iterative encryption datapath. SubWord reuses the existing AES_Sbox byte substitution, the same cell that sub_bytes is built from.

## Interface
Parameters:
- NR, default 10: number of rounds. Only 10 (AES-128) is legal; any other value is an elaboration error.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- KEY_IN  in  128  cipher key. Bits [127:120] are byte 0, so w0 = KEY_IN[127:96]. This is the same MSB-first byte order as the state bus.
- KEY_VALID  in  1  key offered.
- KEY_READY  out  1  block idle; a key is accepted when KEY_VALID && KEY_READY.
- RK_OUT  out  128  current round key, same byte order as KEY_IN.
- RK_ROUND  out  4  index of RK_OUT, 0..10.
- RK_LAST  out  1  high while RK_ROUND == 10 and RK_VALID.
- RK_VALID  out  1  RK_OUT is valid.
- RK_READY  in  1  consumer takes RK_OUT when RK_VALID && RK_READY.

## Operation
- Two states:
  - IDLE: KEY_READY=1, RK_VALID=0.
  - EMIT: KEY_READY=0, RK_VALID=1.
- Reset values: state IDLE, RK_OUT=0, RK_ROUND=0, RK_LAST=0, RK_VALID=0, KEY_READY=1, rcon register=8'h01.
- Transition IDLE -> EMIT on key handshake:
  - RK_OUT <= KEY_IN
  - RK_ROUND <= 0
  - rcon <= 8'h01
- EMIT with a round-key handshake and RK_ROUND < 10:
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord rotates bytes {a,b,c,d} to {b,c,d,a}.
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RK_OUT <= {w0',w1',w2',w3'}; RK_ROUND increments.
  - rcon <= xtime(rcon), where xtime is left-shift by 1, XOR 8'h1B if bit 7 was set. The sequence is 01,02,04,08,10,20,40,80,1B,36.
- EMIT with a handshake and RK_ROUND == 10: go to IDLE. RK_VALID and RK_LAST drop. RK_OUT and RK_ROUND hold their last value.
- EMIT without a handshake: all outputs hold. RK_OUT stays stable while RK_VALID && !RK_READY.
- KEY_VALID is ignored in EMIT, because KEY_READY is low. No key is queued.
- The next-key logic is combinational from RK_OUT and rcon, with a single register stage. There are no multicycle paths.

## Timing
- Key handshake at edge N: round 0 is on RK_OUT with RK_VALID=1 from edge N.
- With RK_READY held high, one round key is produced per cycle. Round k is presented after edge N+k.
- Round 10 is presented after edge N+10. Its handshake at edge N+11 returns the block to IDLE, so KEY_READY=1 after edge N+11.
- There is no combinational path from KEY_VALID or RK_READY to any output. KEY_READY and RK_VALID are decoded from the state register.
- RST_N assertion at any time, including mid-EMIT, immediately forces all reset values. The partial schedule is discarded and does not resume after release.
- After reset release, the first key can be accepted on the first edge.

## Structure
- Shared package aes_pkg holds:
  - AES_NR = 10 and AES_NK = 4
  - the state enum (IDLE, EMIT)
  - function xtime(8-bit)
  - function rot_word(32-bit)
- Sub-module aes_sub_word: a 32-bit wrapper of four AES_Sbox instances (in_byte/out_byte). It is combinational and instantiated once for SubWord.
- The top level holds the FSM, the RK_OUT/RK_ROUND/rcon registers and the XOR chain. Estimated 150-250 lines.

## Test plan
- FIPS-197 A.1, RK_READY held high: load 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: round 0 equals the key.
  - Required: round 1 = a0fafe1788542cb123a339392a6c7605.
  - Required: round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with RK_LAST=1.
  - Required: 11 consecutive valid cycles, then KEY_READY=1.
- All-zero key:
  - Required: round 1 = 62636363626363636263636362636363.
  - Required: round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: FIPS key, RK_READY toggled pseudo-randomly.
  - Required: RK_OUT and RK_ROUND stable while stalled.
  - Required: the round sequence and values are identical to the first scenario.
- Busy rejection: FIPS key loaded, then zero key offered at round 3 with KEY_VALID held high.
  - Required: KEY_READY=0 through round 10 and the schedule is uncorrupted.
  - Required: the zero key is accepted one cycle after the round-10 handshake and yields the zero-key schedule.
- Reset mid-operation: assert RST_N low during round 5.
  - Required: outputs show reset values immediately.
  - Required: after release, a new FIPS key yields the correct round 1 value, so rcon was reset to 01.
